// File: rtl/overture_core.sv
// overture_core: single-cycle 8-bit execute core fed by a combinational program ROM.
// Each rom_data byte is decoded and retired on the next rising clk edge.
// Optional feature macro: OVERTURE_IN_HANDSHAKE_EN. When it is defined, an input-read
// copy waits for in_valid. When it is undefined, in_data is sampled unconditionally.
module overture_core (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid
);

   typedef enum logic [1:0] {
      CLS_IMM  = 2'b00,
      CLS_ALU  = 2'b01,
      CLS_COPY = 2'b10,
      CLS_BR   = 2'b11
   } cls_e;

   typedef struct packed {
      cls_e       cls;
      logic [2:0] src;   // copy source; ignored by ALU and branch
      logic [2:0] lo;    // copy dst / ALU op / branch condition
   } insn_t;

   localparam logic [2:0] SEL_IN   = 3'd6;  // copy source: input port
   localparam logic [2:0] SEL_OUT  = 3'd6;  // copy destination: output port
   localparam logic [2:0] SEL_ZERO = 3'd7;  // copy source: constant zero

   insn_t            insn;
   logic [7:0]       pc_q, pc_d;
   logic [5:0][7:0]  regs_q, regs_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       src_val;
   logic [7:0]       alu_res;
   logic             alu_we;
   logic             r3_zero, r3_neg, br_take;
   logic             rd_in, stall;

   assign insn = insn_t'(rom_data);

   // An input-read copy is the only instruction that can consume in_data.
   assign rd_in    = (insn.cls == CLS_COPY) && (insn.src == SEL_IN);
   assign in_ready = rd_in && rst_n;

`ifdef OVERTURE_IN_HANDSHAKE_EN
   assign stall = rd_in && !in_valid;
`else
   assign stall = 1'b0;
`endif

   assign rom_addr  = pc_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

   // Copy source mux: r0..r5, the input port, or a hard zero.
   always_comb begin
      src_val = 8'h00;
      if (insn.src < SEL_IN)
         src_val = regs_q[insn.src];
      else if (insn.src == SEL_IN)
         src_val = in_data;
   end

   // ALU on r1 and r2. Ops 6 and 7 are no-ops and leave r3 untouched.
   always_comb begin
      alu_res = 8'h00;
      alu_we  = 1'b1;
      case (insn.lo)
         3'd0:    alu_res = regs_q[1] | regs_q[2];
         3'd1:    alu_res = ~(regs_q[1] & regs_q[2]);
         3'd2:    alu_res = ~(regs_q[1] | regs_q[2]);
         3'd3:    alu_res = regs_q[1] & regs_q[2];
         3'd4:    alu_res = regs_q[1] + regs_q[2];
         3'd5:    alu_res = regs_q[1] - regs_q[2];
         default: alu_we  = 1'b0;
      endcase
   end

   // Branch condition on r3, read as a signed two's-complement value.
   assign r3_zero = (regs_q[3] == 8'h00);
   assign r3_neg  = regs_q[3][7];
   always_comb begin
      br_take = 1'b0;
      case (insn.lo)
         3'd0: br_take = 1'b0;
         3'd1: br_take = r3_zero;
         3'd2: br_take = r3_neg;
         3'd3: br_take = r3_neg || r3_zero;
         3'd4: br_take = 1'b1;
         3'd5: br_take = !r3_zero;
         3'd6: br_take = !r3_neg;
         3'd7: br_take = !r3_neg && !r3_zero;
         default: br_take = 1'b0;
      endcase
   end

   // Next architectural state. A stall freezes everything and suppresses the output pulse.
   always_comb begin
      pc_d        = pc_q + 8'd1;
      regs_d      = regs_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      if (stall) begin
         pc_d = pc_q;
      end else begin
         case (insn.cls)
            CLS_IMM:  regs_d[0] = {2'b00, rom_data[5:0]};
            CLS_ALU:  if (alu_we) regs_d[3] = alu_res;
            CLS_COPY: begin
               if (insn.lo < SEL_OUT) begin
                  regs_d[insn.lo] = src_val;
               end else if (insn.lo == SEL_OUT) begin
                  out_data_d  = src_val;
                  out_valid_d = 1'b1;
               end
            end
            CLS_BR:   if (br_take) pc_d = regs_q[0];
            default:  ;
         endcase
      end
   end

   // Architectural registers. Reset is asynchronous and clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= 8'h00;
         regs_q      <= '0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         regs_q      <= regs_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_overture_core.sv
// Bench for overture_core. The bench plays the ROM and issues one directed instruction per cycle.
// Each expected output-port byte goes into a queue. A negedge monitor pops that queue and checks
// every out_valid pulse.
module tb_overture_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rom_addr, rom_data, in_data, out_data;
   logic       in_valid, in_ready, out_valid;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_pc;
   logic [7:0] exp_o;

   overture_core dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one instruction and retire it. The expected PC is advanced unless the
   // instruction is an input read that must stall.
   task automatic step(input logic [7:0] ins, input logic iv = 1'b1, input logic [7:0] id = 8'h00);
      rom_data = ins;
      in_valid = iv;
      in_data  = id;
`ifdef OVERTURE_IN_HANDSHAKE_EN
      if (!(ins[7:6] == 2'b10 && ins[5:3] == 3'd6 && !iv)) exp_pc++;
`else
      exp_pc++;
`endif
      @(posedge clk);
      #1;
   endtask

   // The monitor checks every output pulse against the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: out_data %h with no pending expectation", out_data);
         end else begin
            exp_o = exp_q.pop_front();
            if (out_data !== exp_o) begin
               n_err++;
               $display("FAIL out_data: got %h expected %h", out_data, exp_o);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: in_ready must stay low even when an input read is decoded.
      rst_n = 1'b0; rom_data = 8'hB1; in_valid = 1'b0; in_data = 8'h00; exp_pc = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", rom_addr, 8'h00);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
      chk("rst_in_ready", {7'd0, in_ready}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // First instruction after reset: an immediate load.
      step(8'h01);
      chk("imm_pc", rom_addr, 8'h01);
      exp_q.push_back(8'h01); step(8'h86);

      // Output port: a one-cycle pulse, then the value holds.
      step(8'h05);
      exp_q.push_back(8'h05); step(8'h86);
      chk("out_pc", rom_addr, 8'h04);
      chk("out_valid_hi", {7'd0, out_valid}, 8'h01);
      chk("out_ready_lo", {7'd0, in_ready}, 8'h00);
      step(8'h00);
      chk("out_valid_lo", {7'd0, out_valid}, 8'h00);
      chk("out_hold", out_data, 8'h05);

      // ALU: r1 = 3, r2 = 5.
      step(8'h03); step(8'h81); step(8'h05); step(8'h82);
      step(8'h45); exp_q.push_back(8'hFE); step(8'h9E);
      step(8'h44); exp_q.push_back(8'h08); step(8'h9E);
      // Build r1 = r2 = 0xFF from 0 - 1.
      step(8'h00); step(8'h81); step(8'h01); step(8'h82); step(8'h45);
      step(8'h99); step(8'h9A);
      step(8'h41); exp_q.push_back(8'h00); step(8'h9E);
      step(8'h40); step(8'h47); exp_q.push_back(8'hFF); step(8'h9E);
      step(8'h43); exp_q.push_back(8'hFF); step(8'h9E);
      step(8'h42); exp_q.push_back(8'h00); step(8'h9E);
      exp_q.push_back(8'h00); step(8'hBE);

      // Branches. Here r3 = 0.
      step(8'h0E);
      step(8'hC5);
      chk("br_ne_not", rom_addr, exp_pc);
      step(8'hC1); exp_pc = 8'h0E;
      chk("br_eq_taken", rom_addr, 8'h0E);
      // Build r3 = 0x80 from 0x20 + 0x20 = 0x40, then 0x40 + 0x40.
      step(8'h20); step(8'h81); step(8'h82); step(8'h44); step(8'h99); step(8'h9A); step(8'h44);
      step(8'hC7);
      chk("br_gt_not", rom_addr, exp_pc);
      step(8'hC2); exp_pc = 8'h20;
      chk("br_lt_taken", rom_addr, 8'h20);
      step(8'h3F);
      step(8'hC4); exp_pc = 8'h3F;
      chk("br_always", rom_addr, 8'h3F);
      step(8'hC0);
      chk("br_never", rom_addr, 8'h40);
      // Wrap: load r0 = 0xFF through r3 and jump there.
      step(8'h00); step(8'h81); step(8'h01); step(8'h82); step(8'h45); step(8'h98);
      step(8'hC4); exp_pc = 8'hFF;
      chk("br_to_ff", rom_addr, 8'hFF);
      step(8'h00);
      chk("pc_wrap", rom_addr, 8'h00);

      // Input read to r1 while in_valid is low.
      for (int i = 0; i < 3; i++) begin
         rom_data = 8'hB1; in_valid = 1'b0; #1;
         chk("in_ready_hi", {7'd0, in_ready}, 8'h01);
         step(8'hB1, 1'b0, 8'h11 * (i + 1));
         chk("stall_pc", rom_addr, exp_pc);
      end
      step(8'hB1, 1'b1, 8'h2A);
      chk("in_pc", rom_addr, exp_pc);
      exp_q.push_back(8'h2A); step(8'h8E);
      // Input-to-output copy with in_valid low: this is a stall only when the handshake is enabled.
`ifndef OVERTURE_IN_HANDSHAKE_EN
      exp_q.push_back(8'h55);
`endif
      step(8'hB6, 1'b0, 8'h55);
      chk("pass_stall_pc", rom_addr, exp_pc);
      // Input-to-output pass-through.
      exp_q.push_back(8'h7C); step(8'hB6, 1'b1, 8'h7C);
      chk("pass_valid", {7'd0, out_valid}, 8'h01);

      // Asynchronous reset mid-run, with the output pulse active.
      step(8'h05); exp_q.push_back(8'h05); step(8'h86);
      @(negedge clk); #1;
      rst_n = 1'b0; #1;
      chk("arst_pc", rom_addr, 8'h00);
      chk("arst_out_data", out_data, 8'h00);
      chk("arst_out_valid", {7'd0, out_valid}, 8'h00);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1; exp_pc = 8'h00;
      exp_q.push_back(8'h00); step(8'h86);
      exp_q.push_back(8'h00); step(8'h9E);
      exp_q.push_back(8'h00); step(8'h8E);
      chk("arst_pc_after", rom_addr, 8'h03);

      step(8'h00); step(8'h00);
      chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
